riscv_ascon_regfile_lockable: RTL and testbench

//  Integer register file for the RI5CY core with a parametrised ASCON state window.
//  The state window is NUM_LANES lanes of 2 registers each (hi, low), mapped by ASCON_MAP.

---
 rtl/riscv_ascon_regfile_lockable.sv | 154 +++++++++++++++
 tb/tb_riscv_ascon_regfile_lockable.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ascon_regfile_lockable.sv
// rtl/riscv_ascon_regfile_lockable.sv - RI5CY integer register file with lockable ASCON state window
module riscv_ascon_regfile_lockable #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_LANES      = 5,
  parameter logic [2*NUM_LANES-1:0][ADDR_WIDTH-1:0] ASCON_MAP =
    {5'd31, 5'd30, 5'd29, 5'd28, 5'd17, 5'd16, 5'd15, 5'd14, 5'd13, 5'd12},
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              test_en_i,
  input  logic [ADDR_WIDTH-1:0]             raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]             raddr_b_i,
  input  logic [ADDR_WIDTH-1:0]             raddr_c_i,
  output logic [DATA_WIDTH-1:0]             rdata_a_o,
  output logic [DATA_WIDTH-1:0]             rdata_b_o,
  output logic [DATA_WIDTH-1:0]             rdata_c_o,
  input  logic [ADDR_WIDTH-1:0]             waddr_a_i,
  input  logic [ADDR_WIDTH-1:0]             waddr_b_i,
  input  logic [DATA_WIDTH-1:0]             wdata_a_i,
  input  logic [DATA_WIDTH-1:0]             wdata_b_i,
  input  logic                              we_a_i,
  input  logic                              we_b_i,
  input  logic                              ascon_req_i,
  output logic                              ascon_gnt_o,
  output logic [2*NUM_LANES*DATA_WIDTH-1:0] ascon_state_o,
  input  logic                              ascon_rvalid_i,
  input  logic [2*NUM_LANES*DATA_WIDTH-1:0] ascon_state_i,
  output logic                              ascon_busy_o,
  output logic                              hazard_o,
  output logic                              timeout_o
);

  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam int NUM_MAP   = 2 * NUM_LANES;
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  // Entry 0 is the first lane word; mapping it onto the hardwired zero register is a configuration error.
  if (ASCON_MAP[0] == '0) begin : g_bad_map
    $error("ASCON_MAP entry 0 must not map x0");
  end

  logic [DATA_WIDTH-1:0] mem    [NUM_WORDS];
  logic [DATA_WIDTH-1:0] shadow [NUM_MAP];
  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  gnt, load;
  logic                  map_wa, map_wb, map_ra, map_rb, map_rc;
  logic                  wr_a_ok, wr_b_ok;
  logic                  unused_test_en;

  assign unused_test_en = test_en_i;

  function automatic logic is_mapped(input logic [ADDR_WIDTH-1:0] addr);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_MAP; k++) begin
      if (ASCON_MAP[k] == addr) hit = 1'b1;
    end
    return hit;
  endfunction

  assign map_wa = we_a_i && is_mapped(waddr_a_i);
  assign map_wb = we_b_i && is_mapped(waddr_b_i);
  assign map_ra = is_mapped(raddr_a_i);
  assign map_rb = is_mapped(raddr_b_i);
  assign map_rc = is_mapped(raddr_c_i);

  // While the window is locked, port writes into it are discarded; x0 is never written.
  assign wr_a_ok = we_a_i && (waddr_a_i != '0) && !((state_q == LOCKED) && map_wa);
  assign wr_b_ok = we_b_i && (waddr_b_i != '0) && !((state_q == LOCKED) && map_wb);

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem[raddr_b_i];
  assign rdata_c_o = (raddr_c_i == '0) ? '0 : mem[raddr_c_i];

  for (genvar k = 0; k < NUM_MAP; k++) begin : g_state_out
    assign ascon_state_o[k*DATA_WIDTH +: DATA_WIDTH] = shadow[k];
  end

  // Lock FSM next state, watchdog and handshake outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt          = 1'b0;
    load         = 1'b0;
    ascon_busy_o = 1'b0;
    hazard_o     = 1'b0;
    timeout_o    = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (ascon_req_i && !map_wa && !map_wb) begin
            gnt     = 1'b1;
            state_d = LOCKED;
            cnt_d   = '0;
          end
        end
        LOCKED: begin
          ascon_busy_o = 1'b1;
          hazard_o     = map_wa || map_wb || map_ra || map_rb || map_rc;
          if (ascon_rvalid_i) begin
            load    = 1'b1;
            state_d = IDLE;
          end else if (TIMEOUT_CYCLES != 0) begin
            if (cnt_q == CNT_LAST) begin
              timeout_o = 1'b1;
              state_d   = IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign ascon_gnt_o = gnt;

  // FSM state and watchdog counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Register array and snapshot: port B after A so B wins, accelerator result last so it wins over both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
      for (int k = 0; k < NUM_MAP; k++) shadow[k] <= '0;
    end else begin
      if (wr_a_ok) mem[waddr_a_i] <= wdata_a_i;
      if (wr_b_ok) mem[waddr_b_i] <= wdata_b_i;
      if (load) begin
        for (int k = 0; k < NUM_MAP; k++) begin
          if (ASCON_MAP[k] != '0) mem[ASCON_MAP[k]] <= ascon_state_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (gnt) begin
        for (int k = 0; k < NUM_MAP; k++) shadow[k] <= mem[ASCON_MAP[k]];
      end
    end
  end

endmodule

// File: tb/tb_riscv_ascon_regfile_lockable.sv
// tb/tb_riscv_ascon_regfile_lockable.sv - randomized self-checking bench for the lockable ASCON register file
module tb_riscv_ascon_regfile_lockable;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NM = 10;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic test_en;
  logic [AW-1:0] ra, rb, rc, wa, wb;
  logic [DW-1:0] rda, rdb, rdc, wda, wdb;
  logic wea, web, req, gnt, rvalid, busy, hazard, tmo;
  logic [NM*DW-1:0] st_o, st_i;

  // Free-running core clock.
  always #5 clk = ~clk;

  riscv_ascon_regfile_lockable #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .test_en_i(test_en),
    .raddr_a_i(ra), .raddr_b_i(rb), .raddr_c_i(rc),
    .rdata_a_o(rda), .rdata_b_o(rdb), .rdata_c_o(rdc),
    .waddr_a_i(wa), .waddr_b_i(wb), .wdata_a_i(wda), .wdata_b_i(wdb),
    .we_a_i(wea), .we_b_i(web),
    .ascon_req_i(req), .ascon_gnt_o(gnt), .ascon_state_o(st_o),
    .ascon_rvalid_i(rvalid), .ascon_state_i(st_i),
    .ascon_busy_o(busy), .hazard_o(hazard), .timeout_o(tmo)
  );

  int tests = 0;
  int fails = 0;

  int map_tbl[NM] = '{12, 13, 14, 15, 16, 17, 28, 29, 30, 31};
  logic [DW-1:0] m_mem[32];
  logic [DW-1:0] m_shadow[NM];
  bit m_locked;
  int m_cnt;

  task automatic check(input string tag, input logic [NM*DW-1:0] got, input logic [NM*DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit mapped(input int a);
    foreach (map_tbl[k]) if (map_tbl[k] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_read(input int a);
    return (a == 0) ? '0 : m_mem[a];
  endfunction

  function automatic void m_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    foreach (m_shadow[k]) m_shadow[k] = '0;
    m_locked = 1'b0;
    m_cnt = 0;
  endfunction

  task automatic idle();
    ra = '0; rb = '0; rc = '0; wa = '0; wb = '0; wda = '0; wdb = '0;
    wea = 1'b0; web = 1'b0; req = 1'b0; rvalid = 1'b0; st_i = '0;
  endtask

  // One clock of stimulus: check every output against the model, clock, then advance the model.
  task automatic cycle();
    bit e_gnt, e_haz, e_to, wa_m, wb_m;
    logic [NM*DW-1:0] e_st;
    #1;
    wa_m = wea && mapped(int'(wa));
    wb_m = web && mapped(int'(wb));
    e_gnt = !m_locked && req && !wa_m && !wb_m;
    e_haz = m_locked && (wa_m || wb_m || mapped(int'(ra)) || mapped(int'(rb)) || mapped(int'(rc)));
    e_to = m_locked && !rvalid && (m_cnt == TO - 1);
    for (int k = 0; k < NM; k++) e_st[k*DW +: DW] = m_shadow[k];
    check("rdata_a", rda, m_read(int'(ra)));
    check("rdata_b", rdb, m_read(int'(rb)));
    check("rdata_c", rdc, m_read(int'(rc)));
    check("gnt", gnt, e_gnt);
    check("busy", busy, m_locked);
    check("hazard", hazard, e_haz);
    check("timeout", tmo, e_to);
    check("state_o", st_o, e_st);
    @(posedge clk);
    #1;
    if (e_gnt) for (int k = 0; k < NM; k++) m_shadow[k] = m_mem[map_tbl[k]];
    if (wea && wa != 0 && !(m_locked && mapped(int'(wa)))) m_mem[wa] = wda;
    if (web && wb != 0 && !(m_locked && mapped(int'(wb)))) m_mem[wb] = wdb;
    if (m_locked) begin
      if (rvalid) begin
        for (int k = 0; k < NM; k++) m_mem[map_tbl[k]] = st_i[k*DW +: DW];
        m_locked = 1'b0;
      end else if (m_cnt == TO - 1) begin
        m_locked = 1'b0;
      end else begin
        m_cnt++;
      end
    end else if (e_gnt) begin
      m_locked = 1'b1;
      m_cnt = 0;
    end
  endtask

  initial begin
    test_en = 1'b0;
    idle();
    rst = 1'b1;
    req = 1'b1;
    ra = 5'd12;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_hazard", hazard, 0);
    check("rst_timeout", tmo, 0);
    check("rst_rdata", rda, 0);
    check("rst_state", st_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    idle();

    // Write then read back the first mapped register.
    wea = 1'b1; wa = 5'd12; wda = 32'hA5A5_0001;
    cycle();
    idle(); ra = 5'd12;
    #1 check("rd_reg12", rda, 32'hA5A5_0001);
    cycle();

    // Dual write to one address, and a write to x0.
    wea = 1'b1; wa = 5'd5; wda = 32'h1; web = 1'b1; wb = 5'd5; wdb = 32'h2;
    cycle();
    idle(); wea = 1'b1; wa = 5'd0; wda = 32'hFF;
    cycle();
    idle(); ra = 5'd5; rb = 5'd0;
    #1;
    check("port_b_wins", rda, 32'h2);
    check("x0_zero", rdb, 32'h0);
    cycle();

    // Snapshot and accelerator result.
    for (int k = 0; k < NM; k++) begin
      idle(); wea = 1'b1; wa = AW'(map_tbl[k]); wda = 32'h100 + k;
      cycle();
    end
    idle(); req = 1'b1;
    #1 check("snap_gnt", gnt, 1);
    cycle();
    idle();
    #1 check("snap_busy", busy, 1);
    for (int k = 0; k < NM; k++) check("snap_slice", st_o[k*DW +: DW], 32'h100 + k);
    rvalid = 1'b1;
    for (int k = 0; k < NM; k++) st_i[k*DW +: DW] = 32'h200 + k;
    cycle();
    idle();
    #1 check("result_busy", busy, 0);
    for (int k = 0; k < NM; k++) begin
      ra = AW'(map_tbl[k]);
      #1 check("result_reg", rda, 32'h200 + k);
    end
    cycle();

    // Denied request, then granted with the freshly written value.
    idle(); req = 1'b1; web = 1'b1; wb = 5'd30; wdb = 32'h3030;
    #1 check("deny_gnt", gnt, 0);
    cycle();
    idle(); req = 1'b1;
    #1 check("retry_gnt", gnt, 1);
    cycle();
    idle();
    #1 check("slice8", st_o[8*DW +: DW], 32'h3030);

    // Locked hazards.
    wea = 1'b1; wa = 5'd14; wda = 32'hDEAD;
    #1 check("haz_mapped", hazard, 1);
    cycle();
    idle(); wea = 1'b1; wa = 5'd5; wda = 32'h55;
    #1 check("haz_unmapped", hazard, 0);
    cycle();
    idle(); ra = 5'd14; rb = 5'd5;
    #1;
    check("reg14_kept", rda, 32'h202);
    check("reg5_upd", rdb, 32'h55);
    cycle();
    idle();
    repeat (3) cycle();

    // Watchdog expiry, then rvalid on the expiry cycle.
    idle(); req = 1'b1;
    cycle();
    idle();
    repeat (3) cycle();
    #1 check("wd_pulse", tmo, 1);
    cycle();
    #1 check("wd_busy", busy, 0);
    req = 1'b1;
    cycle();
    idle();
    repeat (3) cycle();
    rvalid = 1'b1;
    for (int k = 0; k < NM; k++) st_i[k*DW +: DW] = 32'h300 + k;
    #1 check("wd_rvalid_nopulse", tmo, 0);
    cycle();
    idle(); ra = 5'd12;
    #1 check("wd_rvalid_reg12", rda, 32'h300);
    cycle();

    // Reset in the middle of LOCKED; an rvalid right after reset is ignored.
    req = 1'b1;
    cycle();
    idle();
    cycle();
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    ra = 5'd12;
    #1 check("midrst_reg", rda, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    idle();
    rvalid = 1'b1;
    for (int k = 0; k < NM; k++) st_i[k*DW +: DW] = $urandom;
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      ra = AW'($urandom_range(0, 31));
      rb = AW'($urandom_range(0, 31));
      rc = AW'($urandom_range(0, 31));
      wa = AW'($urandom_range(0, 31));
      wb = AW'($urandom_range(0, 31));
      wda = $urandom;
      wdb = $urandom;
      wea = ($urandom % 2) == 0;
      web = ($urandom % 3) == 0;
      req = ($urandom % 10) < 3;
      rvalid = ($urandom % 8) == 0;
      for (int k = 0; k < NM; k++) st_i[k*DW +: DW] = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
